// File: rtl/sitcp_tx_framer.sv
// sitcp_tx_framer: multi-channel event framer feeding the SiTCP TCP TX byte port.
// Each channel owns a one-entry buffer; a round-robin arbiter drains the buffers
// into frames of HDR, CH, SEQ, payload (MSB first), CSUM under TX_FULL backpressure.
module sitcp_tx_framer #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_BYTES = 2,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           ENABLE,
    input  logic [NUM_CH-1:0]              CH_STB,
    input  logic [NUM_CH*8*DATA_BYTES-1:0] CH_DATA,
    output logic [NUM_CH-1:0]              CH_BUSY,
    input  logic                           TX_FULL,
    output logic                           TX_WR,
    output logic [7:0]                     TX_DATA,
    output logic [15:0]                    DROP_CNT
);

    localparam int unsigned DW  = 8 * DATA_BYTES;
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BIW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned DCW = $clog2(NUM_CH + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_CH   = 3'd2;
    localparam logic [2:0] ST_SEQ  = 3'd3;
    localparam logic [2:0] ST_PAY  = 3'd4;
    localparam logic [2:0] ST_CSUM = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [DW-1:0]     buf_q [NUM_CH];
    logic [DW-1:0]     buf_d [NUM_CH];
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [CHW-1:0]    rr_q, rr_d;
    logic [7:0]        seq_q, seq_d;
    logic [DW-1:0]     sr_q, sr_d;
    logic [3:0]        ch_q, ch_d;
    logic [7:0]        csum_q, csum_d;
    logic [BIW-1:0]    bidx_q, bidx_d;
    logic              tx_wr_q, tx_wr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [15:0]       drop_q, drop_d;

    logic              gnt_any;
    logic [CHW-1:0]    gnt_idx;
    logic [31:0]       arb_pos;
    logic [DW-1:0]     gnt_word;
    logic [7:0]        gnt_pxor;
    logic [7:0]        cur_byte;
    logic              grant_now;
    logic [DCW-1:0]    ndrop;
    logic [16:0]       drop_sum;

    // Round-robin pick: first busy channel at or after rr_q, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        arb_pos = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            arb_pos = 32'(rr_q) + 32'(k);
            if (arb_pos >= NUM_CH) begin
                arb_pos = arb_pos - NUM_CH;
            end
            if (!gnt_any && busy_q[arb_pos[CHW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = arb_pos[CHW-1:0];
            end
        end
    end

    // Granted word and the XOR of its bytes, used to precompute the checksum.
    always_comb begin
        gnt_word = buf_q[gnt_idx];
        gnt_pxor = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            gnt_pxor = gnt_pxor ^ gnt_word[b*8 +: 8];
        end
    end

    // Byte presented by the current emit state.
    always_comb begin
        cur_byte = '0;
        case (state_q)
            ST_HDR:  cur_byte = HDR_BYTE;
            ST_CH:   cur_byte = {4'h0, ch_q};
            ST_SEQ:  cur_byte = seq_q;
            ST_PAY:  cur_byte = sr_q[DW-1 -: 8];
            ST_CSUM: cur_byte = csum_q;
            default: cur_byte = '0;
        endcase
    end

    assign grant_now = ENABLE && (state_q == ST_IDLE) && gnt_any;

    // Next-state: buffers, drop counting, arbitration and frame emission.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        busy_d    = busy_q;
        rr_d      = rr_q;
        seq_d     = seq_q;
        sr_d      = sr_q;
        ch_d      = ch_q;
        csum_d    = csum_q;
        bidx_d    = bidx_q;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        drop_d    = drop_q;
        ndrop     = '0;
        drop_sum  = '0;

        if (!ENABLE) begin
            // Synchronous flush; drop count is deliberately kept.
            state_d = ST_IDLE;
            busy_d  = '0;
            rr_d    = '0;
            seq_d   = '0;
        end else begin
            // Channel buffers: a strobe on the channel being granted reloads it.
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant_now && (gnt_idx == CHW'(i))) begin
                    busy_d[i] = 1'b0;
                end
                if (CH_STB[i]) begin
                    if (busy_q[i] && !(grant_now && (gnt_idx == CHW'(i)))) begin
                        ndrop = ndrop + DCW'(1);
                    end else begin
                        buf_d[i]  = CH_DATA[i*DW +: DW];
                        busy_d[i] = 1'b1;
                    end
                end
            end
            drop_sum = {1'b0, drop_q} + 17'(ndrop);
            drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        sr_d    = gnt_word;
                        ch_d    = 4'(gnt_idx);
                        csum_d  = HDR_BYTE ^ {4'h0, 4'(gnt_idx)} ^ seq_q ^ gnt_pxor;
                        bidx_d  = '0;
                        state_d = ST_HDR;
                        if (32'(gnt_idx) == NUM_CH - 1) begin
                            rr_d = '0;
                        end else begin
                            rr_d = gnt_idx + CHW'(1);
                        end
                    end
                end
                ST_HDR, ST_CH, ST_SEQ, ST_PAY, ST_CSUM: begin
                    if (!TX_FULL) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = cur_byte;
                        case (state_q)
                            ST_HDR: state_d = ST_CH;
                            ST_CH:  state_d = ST_SEQ;
                            ST_SEQ: state_d = ST_PAY;
                            ST_PAY: begin
                                sr_d = sr_q << 8;
                                if (bidx_q == BIW'(DATA_BYTES - 1)) begin
                                    state_d = ST_CSUM;
                                end else begin
                                    bidx_d = bidx_q + BIW'(1);
                                end
                            end
                            default: begin
                                seq_d   = seq_q + 8'd1;
                                state_d = ST_IDLE;
                            end
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < NUM_CH; i++) begin
                buf_q[i] <= '0;
            end
            busy_q    <= '0;
            rr_q      <= '0;
            seq_q     <= '0;
            sr_q      <= '0;
            ch_q      <= '0;
            csum_q    <= '0;
            bidx_q    <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            busy_q    <= busy_d;
            rr_q      <= rr_d;
            seq_q     <= seq_d;
            sr_q      <= sr_d;
            ch_q      <= ch_d;
            csum_q    <= csum_d;
            bidx_q    <= bidx_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
            drop_q    <= drop_d;
        end
    end

    assign CH_BUSY  = busy_q;
    assign TX_WR    = tx_wr_q;
    assign TX_DATA  = tx_data_q;
    assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_sitcp_tx_framer.sv
// Bench for sitcp_tx_framer: directed frame tables, multi-cycle corner cases,
// and randomized traffic checked cycle by cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_sitcp_tx_framer;

    localparam int unsigned NCH = 4;
    localparam int unsigned DB  = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              ENABLE;
    logic [NCH-1:0]    CH_STB;
    logic [NCH*16-1:0] CH_DATA;
    logic [NCH-1:0]    CH_BUSY;
    logic              TX_FULL;
    logic              TX_WR;
    logic [7:0]        TX_DATA;
    logic [15:0]       DROP_CNT;

    sitcp_tx_framer #(.NUM_CH(NCH), .DATA_BYTES(DB), .HDR_BYTE(8'hA5)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .CH_STB(CH_STB), .CH_DATA(CH_DATA),
        .CH_BUSY(CH_BUSY), .TX_FULL(TX_FULL), .TX_WR(TX_WR), .TX_DATA(TX_DATA),
        .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] mon_data[$];
    int         mon_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Byte capture: every written byte with the cycle it was on the bus.
    always @(negedge CLK) begin
        if (TX_WR === 1'b1) begin
            mon_data.push_back(TX_DATA);
            mon_cyc.push_back(cyc);
        end
    end

    // Reference model: pending words per channel and the byte list of the frame in flight.
    bit   [NCH-1:0] m_busy;
    bit   [NCH-1:0] m_pre;
    logic [15:0]    m_buf[NCH];
    int             m_rr, m_seq, m_drop, m_g, m_nd;
    bit             m_wr;
    logic [7:0]     m_data;
    logic [7:0]     m_fq[$];
    logic [7:0]     m_x;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy = '0; m_rr = 0; m_seq = 0; m_drop = 0;
            m_wr = 1'b0; m_data = 8'h00; m_fq.delete();
        end else begin
            m_pre = m_busy;
            m_g   = -1;
            m_nd  = 0;
            m_wr  = 1'b0;
            if (!ENABLE) begin
                m_busy = '0; m_rr = 0; m_seq = 0; m_fq.delete();
            end else begin
                if (m_fq.size() > 0) begin
                    if (!TX_FULL) begin
                        m_wr   = 1'b1;
                        m_data = m_fq.pop_front();
                        if (m_fq.size() == 0) m_seq = (m_seq + 1) % 256;
                    end
                end else begin
                    for (int k = 0; k < NCH; k++)
                        if (m_g < 0 && m_pre[(m_rr + k) % NCH]) m_g = (m_rr + k) % NCH;
                    if (m_g >= 0) begin
                        m_fq.push_back(8'hA5);
                        m_fq.push_back(8'(m_g));
                        m_fq.push_back(8'(m_seq));
                        m_fq.push_back(m_buf[m_g][15:8]);
                        m_fq.push_back(m_buf[m_g][7:0]);
                        m_x = 8'hA5 ^ 8'(m_g) ^ 8'(m_seq) ^ m_buf[m_g][15:8] ^ m_buf[m_g][7:0];
                        m_fq.push_back(m_x);
                        m_busy[m_g] = 1'b0;
                        m_rr = (m_g + 1) % NCH;
                    end
                end
                for (int i = 0; i < NCH; i++) begin
                    if (CH_STB[i]) begin
                        if (m_pre[i] && m_g != i) m_nd++;
                        else begin
                            m_buf[i]  = CH_DATA[i*16 +: 16];
                            m_busy[i] = 1'b1;
                        end
                    end
                end
                m_drop = (m_drop + m_nd > 65535) ? 65535 : m_drop + m_nd;
            end
        end
    end

    // Lockstep comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk($sformatf("ls_tx_wr@%0d", cyc), 32'(TX_WR), 32'(m_wr));
        chk($sformatf("ls_tx_data@%0d", cyc), 32'(TX_DATA), 32'(m_data));
        chk($sformatf("ls_ch_busy@%0d", cyc), 32'(CH_BUSY), 32'(m_busy));
        chk($sformatf("ls_drop_cnt@%0d", cyc), 32'(DROP_CNT), 32'(m_drop));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; CH_STB = '0; TX_FULL = 1'b0; ENABLE = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(1);
        mon_data.delete();
        mon_cyc.delete();
    endtask

    task automatic strobe(input logic [NCH-1:0] m, output int s);
        CH_STB = m;
        s = cyc;
        tick(1);
        CH_STB = '0;
    endtask

    task automatic set_data(input int ch, input logic [15:0] v);
        CH_DATA[ch*16 +: 16] = v;
    endtask

    // Frame check: bytes from the frame rules, cycles contiguous except a stall after byte sidx.
    task automatic check_frame(input string nm, input int base, input int start,
                               input logic [3:0] ch, input logic [7:0] seq,
                               input logic [15:0] d, input int sidx, input int stall);
        logic [7:0] e[6];
        e[0] = 8'hA5; e[1] = {4'h0, ch}; e[2] = seq; e[3] = d[15:8]; e[4] = d[7:0];
        e[5] = e[0] ^ e[1] ^ e[2] ^ e[3] ^ e[4];
        if (mon_data.size() < base + 6) begin
            chk({nm, "_len"}, 32'(mon_data.size()), 32'(base + 6));
            return;
        end
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("%s_b%0d", nm, j), 32'(mon_data[base+j]), 32'(e[j]));
            chk($sformatf("%s_c%0d", nm, j), 32'(mon_cyc[base+j]),
                32'(start + j + ((j > sidx) ? stall : 0)));
        end
    endtask

    typedef struct {
        int          ch;
        logic [15:0] data;
        logic [7:0]  seq;
        logic [7:0]  csum;
    } vec_t;

    vec_t tbl[4];
    int   s, s2, s3, base;

    initial begin
        tbl[0] = '{ch: 2, data: 16'h1234, seq: 8'h00, csum: 8'h81};
        tbl[1] = '{ch: 0, data: 16'hABCD, seq: 8'h01, csum: 8'hC2};
        tbl[2] = '{ch: 3, data: 16'h0000, seq: 8'h02, csum: 8'hA4};
        tbl[3] = '{ch: 1, data: 16'hFFFF, seq: 8'h03, csum: 8'hA7};

        RST = 1'b1; ENABLE = 1'b1; CH_STB = '0; CH_DATA = '0; TX_FULL = 1'b0;
        do_reset();

        // Single frames from the table, latency 3 and exactly six writes each.
        for (int i = 0; i < 4; i++) begin
            set_data(tbl[i].ch, tbl[i].data);
            strobe(4'(1 << tbl[i].ch), s);
            tick(10);
            check_frame($sformatf("tbl%0d", i), 6*i, s + 3, 4'(tbl[i].ch), tbl[i].seq,
                        tbl[i].data, 99, 0);
            chk($sformatf("tbl%0d_count", i), 32'(mon_data.size()), 32'(6*(i+1)));
            if (mon_data.size() >= 6*(i+1))
                chk($sformatf("tbl%0d_csum", i), 32'(mon_data[6*i+5]), 32'(tbl[i].csum));
        end

        // All four channels at once, then ch3 and ch1 after the pointer wrapped.
        do_reset();
        for (int i = 0; i < 4; i++) set_data(i, 16'(16'h1111 * (i + 1)));
        strobe(4'b1111, s);
        tick(30);
        for (int k = 0; k < 4; k++)
            check_frame($sformatf("rr%0d", k), 6*k, s + 3 + 7*k, 4'(k), 8'(k),
                        16'(16'h1111 * (k + 1)), 99, 0);
        strobe(4'b1010, s2);
        tick(16);
        check_frame("rr_b1", 24, s2 + 3, 4'd1, 8'h04, 16'h2222, 99, 0);
        check_frame("rr_b3", 30, s2 + 10, 4'd3, 8'h05, 16'h4444, 99, 0);
        chk("rr_count", 32'(mon_data.size()), 32'd36);

        // Ten-cycle stall after payload byte 0.
        do_reset();
        set_data(2, 16'hBEEF);
        strobe(4'b0100, s);
        tick(5);
        TX_FULL = 1'b1;
        tick(10);
        TX_FULL = 1'b0;
        tick(6);
        check_frame("stall", 0, s + 3, 4'd2, 8'h00, 16'hBEEF, 3, 10);
        chk("stall_count", 32'(mon_data.size()), 32'd6);

        // Drops while held full, then saturation, then drain in round-robin order.
        do_reset();
        TX_FULL = 1'b1;
        strobe(4'b0001, s);
        tick(2);
        strobe(4'b0001, s);
        strobe(4'b0001, s);
        chk("drop_one", 32'(DROP_CNT), 32'd1);
        strobe(4'b1110, s);
        strobe(4'b1110, s);
        chk("drop_four", 32'(DROP_CNT), 32'd4);
        chk("drop_busy", 32'(CH_BUSY), 32'hF);
        CH_STB = 4'b1111;
        tick(16400);
        CH_STB = '0;
        chk("drop_sat", 32'(DROP_CNT), 32'hFFFF);
        TX_FULL = 1'b0;
        tick(40);
        chk("drain_count", 32'(mon_data.size()), 32'd30);
        if (mon_data.size() >= 30) begin
            chk("drain_ch0", 32'(mon_data[1]), 32'd0);
            chk("drain_ch1", 32'(mon_data[7]), 32'd1);
            chk("drain_ch2", 32'(mon_data[13]), 32'd2);
            chk("drain_ch3", 32'(mon_data[19]), 32'd3);
            chk("drain_ch4", 32'(mon_data[25]), 32'd0);
        end
        chk("drop_hold", 32'(DROP_CNT), 32'hFFFF);

        // ENABLE low during the SEQ byte abandons the frame and clears state.
        do_reset();
        set_data(0, 16'h0102);
        strobe(4'b0001, s);
        tick(10);
        set_data(2, 16'h7777);
        strobe(4'b0100, s);
        strobe(4'b1000, s2);
        tick(3);
        chk("en_seq_wr", 32'(TX_WR), 32'd1);
        chk("en_seq_byte", 32'(TX_DATA), 32'h01);
        ENABLE = 1'b0;
        tick(1);
        chk("en_off_wr", 32'(TX_WR), 32'd0);
        chk("en_off_busy", 32'(CH_BUSY), 32'd0);
        ENABLE = 1'b1;
        tick(2);
        base = mon_data.size();
        chk("en_partial", 32'(base), 32'd9);
        set_data(1, 16'h5A5A);
        strobe(4'b0010, s3);
        tick(10);
        check_frame("en_resume", base, s3 + 3, 4'd1, 8'h00, 16'h5A5A, 99, 0);

        // Random traffic with a reset pulse in the middle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ENABLE  = ($urandom_range(0, 63) != 0);
            TX_FULL = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < NCH; i++) CH_STB[i] = ($urandom_range(0, 4) == 0);
            CH_DATA = {$urandom, $urandom};
            if (c == 1500) begin
                RST = 1'b1;
                #1;
                chk("rst_tx_wr", 32'(TX_WR), 32'd0);
                chk("rst_tx_data", 32'(TX_DATA), 32'd0);
                chk("rst_ch_busy", 32'(CH_BUSY), 32'd0);
                chk("rst_drop", 32'(DROP_CNT), 32'd0);
                tick(1);
                RST = 1'b0;
            end else begin
                tick(1);
            end
        end
        CH_STB = '0;
        TX_FULL = 1'b0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
